// File: rtl/nano_io_port.sv
// nano_io_port: I/O responder for the Nano processor.
// The output side is a small FIFO fed by LdOUTPUT pulses and drained over
// valid/ready. The input side is a one-word holding register filled over
// valid/ready and consumed by RdINPUT. Sticky flags record dropped pushes
// and reads of an empty holding register.
module nano_io_port #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             LdOUTPUT,
  input  logic [WIDTH-1:0] DataOUT,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_full,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             RdINPUT,
  output logic [WIDTH-1:0] DataIN,
  output logic             in_avail,
  input  logic             clr_err,
  output logic             err_ovf,
  output logic             err_unf
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } in_state_t;

  // Output FIFO state
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW-1:0]    wr_ptr_reg;
  logic [CW-1:0]    count_reg;
  logic             err_ovf_reg;

  // Input holding register state
  in_state_t        in_state_reg;
  logic [WIDTH-1:0] data_in_reg;
  logic             in_ready_reg;
  logic             in_avail_reg;
  logic             err_unf_reg;

  logic pop;
  logic push_ok;
  logic push_drop;
  logic rd_empty;

  // A push is only refused when the FIFO is full and nothing leaves this cycle.
  assign out_valid = (count_reg != '0);
  assign out_full  = (count_reg == FULL_COUNT);
  assign pop       = out_valid & out_ready;
  assign push_ok   = LdOUTPUT & (~out_full | pop);
  assign push_drop = LdOUTPUT & out_full & ~pop;
  assign rd_empty  = RdINPUT & (in_state_reg == ST_EMPTY);

  // Head is forced to zero while empty so the reset value is well defined;
  // while valid it only depends on registered state, so it holds under stall.
  assign out_data = out_valid ? mem[rd_ptr_reg] : '0;

  assign in_ready = in_ready_reg;
  assign in_avail = in_avail_reg;
  assign DataIN   = data_in_reg;
  assign err_ovf  = err_ovf_reg;
  assign err_unf  = err_unf_reg;

  // FIFO storage write; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr_reg] <= DataOUT;
    end
  end

  // FIFO pointers, occupancy and overflow flag (set beats clear).
  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_ptr_reg  <= '0;
      wr_ptr_reg  <= '0;
      count_reg   <= '0;
      err_ovf_reg <= 1'b0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)     rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push_ok, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
      if (push_drop)    err_ovf_reg <= 1'b1;
      else if (clr_err) err_ovf_reg <= 1'b0;
    end
  end

  // Holding register FSM with registered handshake outputs and underflow flag.
  always_ff @(posedge clk) begin
    if (!rst) begin
      in_state_reg <= ST_EMPTY;
      data_in_reg  <= '0;
      in_ready_reg <= 1'b1;
      in_avail_reg <= 1'b0;
      err_unf_reg  <= 1'b0;
    end else begin
      case (in_state_reg)
        ST_EMPTY: begin
          if (in_valid) begin
            data_in_reg  <= in_data;
            in_state_reg <= ST_FULL;
            in_ready_reg <= 1'b0;
            in_avail_reg <= 1'b1;
          end
        end
        ST_FULL: begin
          // DataIN deliberately keeps its value after the consume.
          if (RdINPUT) begin
            in_state_reg <= ST_EMPTY;
            in_ready_reg <= 1'b1;
            in_avail_reg <= 1'b0;
          end
        end
        default: begin
          in_state_reg <= ST_EMPTY;
          in_ready_reg <= 1'b1;
          in_avail_reg <= 1'b0;
        end
      endcase
      if (rd_empty)     err_unf_reg <= 1'b1;
      else if (clr_err) err_unf_reg <= 1'b0;
    end
  end

endmodule
